// File: rtl/dpram_pkg.sv
// Shared constants and types for the byte-enabled dual-port RAM with reset-driven clear.
package dpram_pkg;

    localparam int RDW_WRITE_FIRST = 0;
    localparam int RDW_READ_FIRST  = 1;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    function automatic int bytes_of(input int w);
        return w / 8;
    endfunction

endpackage

// File: rtl/dpram_clear_seq.sv
// Post-reset clear sequencer: walks half the address space per port so both ports
// together zero the whole memory in 2**(depth-1) cycles.
module dpram_clear_seq
    import dpram_pkg::*;
#(
    parameter int depth          = 8,
    parameter int clear_on_reset = 1
) (
    input  logic             clock,
    input  logic             reset,
    output logic             busy,
    output logic             clr_we,
    output logic [depth-2:0] clr_addr
);

    state_t           state_q;
    state_t           state_d;
    logic [depth-2:0] cnt_q;
    logic [depth-2:0] cnt_d;
    logic             reset_q;

    always_ff @(posedge clock) begin
        reset_q <= reset;
        if (reset) begin
            state_q <= (clear_on_reset != 0) ? ST_CLEAR : ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The last clear write happens at cnt == all-ones; RUN follows on the same edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        if (state_q == ST_CLEAR) begin
            clr_we = !reset;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == '1) begin
                state_d = ST_RUN;
            end
        end
    end

    assign busy     = reset_q | (state_q == ST_CLEAR);
    assign clr_addr = cnt_q;

endmodule

// File: rtl/dpram_be_clr.sv
// True dual-port RAM with byte enables, selectable read-during-write, optional output
// register, same-address collision protection and a reset-triggered clear sequence.
module dpram_be_clr
    import dpram_pkg::*;
#(
    parameter int depth          = 8,
    parameter int width          = 32,
    parameter int out_reg        = 0,
    parameter int rdw_mode       = 0,
    parameter int clear_on_reset = 1
) (
    input  logic               clock,
    input  logic               reset,
    output logic               busy,
    output logic               collision,
    input  logic               wren_a,
    input  logic               wren_b,
    input  logic [width/8-1:0] byteena_a,
    input  logic [width/8-1:0] byteena_b,
    input  logic [depth-1:0]   address_a,
    input  logic [depth-1:0]   address_b,
    input  logic [width-1:0]   data_a,
    input  logic [width-1:0]   data_b,
    output logic [width-1:0]   q_a,
    output logic [width-1:0]   q_b
);

    localparam int BYTES = bytes_of(width);
    localparam int WORDS = 2 ** depth;

    function automatic logic [width-1:0] rdw_view(input logic [width-1:0] old_w,
                                                 input logic [width-1:0] new_w,
                                                 input logic [BYTES-1:0] be,
                                                 input logic             we);
        logic [width-1:0] r;
        r = old_w;
        case (rdw_mode)
            RDW_WRITE_FIRST: begin
                for (int i = 0; i < BYTES; i++) begin
                    if (we && be[i]) r[8*i +: 8] = new_w[8*i +: 8];
                end
            end
            RDW_READ_FIRST: r = old_w;
            default:        r = old_w;
        endcase
        return r;
    endfunction

    logic             clr_we;
    logic [depth-2:0] clr_addr;

    dpram_clear_seq #(
        .depth          (depth),
        .clear_on_reset (clear_on_reset)
    ) u_clear_seq (
        .clock    (clock),
        .reset    (reset),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    logic user_ok;
    logic coll;

    assign user_ok = !busy && !reset;
    assign coll    = user_ok && wren_a && wren_b && (address_a == address_b);

    logic             we_a,   we_b;
    logic [BYTES-1:0] be_a,   be_b;
    logic [depth-1:0] addr_a, addr_b;
    logic [width-1:0] wd_a,   wd_b;

    // Clear writes take over both ports; A covers the low half, B the high half.
    always_comb begin
        we_a   = user_ok && wren_a;
        be_a   = byteena_a;
        addr_a = address_a;
        wd_a   = data_a;
        we_b   = user_ok && wren_b && !coll;
        be_b   = byteena_b;
        addr_b = address_b;
        wd_b   = data_b;
        if (clr_we) begin
            we_a   = 1'b1;
            be_a   = '1;
            addr_a = {1'b0, clr_addr};
            wd_a   = '0;
            we_b   = 1'b1;
            be_b   = '1;
            addr_b = {1'b1, clr_addr};
            wd_b   = '0;
        end
    end

    (* ram_style = "block" *) logic [width-1:0] mem [WORDS];

    always_ff @(posedge clock) begin
        for (int i = 0; i < BYTES; i++) begin
            if (we_a && be_a[i]) mem[addr_a][8*i +: 8] <= wd_a[8*i +: 8];
            if (we_b && be_b[i]) mem[addr_b][8*i +: 8] <= wd_b[8*i +: 8];
        end
    end

    // ---- stage p1: array read, read-during-write view, collision flag ----
    logic [width-1:0] rd_a_p1, rd_b_p1;
    logic             vld_p1;
    logic             col_p1;

    always_ff @(posedge clock) begin
        rd_a_p1 <= rdw_view(mem[addr_a], wd_a, be_a, we_a);
        rd_b_p1 <= rdw_view(mem[addr_b], wd_b, be_b, we_b);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            col_p1 <= 1'b0;
        end else begin
            vld_p1 <= user_ok;
            col_p1 <= coll;
        end
    end

    assign collision = col_p1;

    logic [width-1:0] rd_a_o, rd_b_o;
    logic             vld_o;

    // ---- stage p2: optional output register ----
    if (out_reg != 0) begin : g_out_reg
        logic [width-1:0] rd_a_p2, rd_b_p2;
        logic             vld_p2;

        always_ff @(posedge clock) begin
            rd_a_p2 <= rd_a_p1;
            rd_b_p2 <= rd_b_p1;
        end

        always_ff @(posedge clock) begin
            if (reset) vld_p2 <= 1'b0;
            else       vld_p2 <= vld_p1;
        end

        assign rd_a_o = rd_a_p2;
        assign rd_b_o = rd_b_p2;
        assign vld_o  = vld_p2;
    end else begin : g_no_out_reg
        assign rd_a_o = rd_a_p1;
        assign rd_b_o = rd_b_p1;
        assign vld_o  = vld_p1;
    end

    assign q_a = (vld_o && !busy) ? rd_a_o : '0;
    assign q_b = (vld_o && !busy) ? rd_b_o : '0;

endmodule

// File: tb/tb_dpram_be_clr.sv
// Bench for dpram_be_clr: three configurations share one stimulus stream and are
// checked every cycle against an array-level model, plus directed literal checks.
module tb_dpram_be_clr;

    logic        clock = 1'b0;
    logic        reset;
    logic        wren_a, wren_b;
    logic [3:0]  byteena_a, byteena_b;
    logic [5:0]  address_a, address_b;
    logic [31:0] data_a, data_b;

    logic [2:0]  busy_o;
    logic [2:0]  coll_o;
    logic [31:0] qa_o [3];
    logic [31:0] qb_o [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    dpram_be_clr #(.depth(4), .width(32), .out_reg(0), .rdw_mode(0), .clear_on_reset(1)) dut0 (
        .clock(clock), .reset(reset), .busy(busy_o[0]), .collision(coll_o[0]),
        .wren_a(wren_a), .wren_b(wren_b), .byteena_a(byteena_a), .byteena_b(byteena_b),
        .address_a(address_a[3:0]), .address_b(address_b[3:0]),
        .data_a(data_a), .data_b(data_b), .q_a(qa_o[0]), .q_b(qb_o[0]));

    dpram_be_clr #(.depth(4), .width(32), .out_reg(1), .rdw_mode(1), .clear_on_reset(1)) dut1 (
        .clock(clock), .reset(reset), .busy(busy_o[1]), .collision(coll_o[1]),
        .wren_a(wren_a), .wren_b(wren_b), .byteena_a(byteena_a), .byteena_b(byteena_b),
        .address_a(address_a[3:0]), .address_b(address_b[3:0]),
        .data_a(data_a), .data_b(data_b), .q_a(qa_o[1]), .q_b(qb_o[1]));

    dpram_be_clr #(.depth(6), .width(32), .out_reg(0), .rdw_mode(0), .clear_on_reset(1)) dut2 (
        .clock(clock), .reset(reset), .busy(busy_o[2]), .collision(coll_o[2]),
        .wren_a(wren_a), .wren_b(wren_b), .byteena_a(byteena_a), .byteena_b(byteena_b),
        .address_a(address_a), .address_b(address_b),
        .data_a(data_a), .data_b(data_b), .q_a(qa_o[2]), .q_b(qb_o[2]));

    function automatic int dep_of(input int k);
        return (k == 2) ? 6 : 4;
    endfunction

    function automatic bit oreg_of(input int k);
        return (k == 1);
    endfunction

    function automatic bit rdfirst_of(input int k);
        return (k == 1);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act,
                       input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h, expected %h at %0t", nm, k, act, want, $time);
        end
    endtask

    // Behavioural model: memory as plain arrays, busy as a remaining-cycle count.
    logic [31:0] mm [3][64];
    logic [31:0] p1a [3], p1b [3], p2a [3], p2b [3];
    bit   [2:0]  m_busy;
    bit   [2:0]  m_col;
    int          m_rem [3];
    bit          model_ok = 1'b0;

    task automatic model_step(input int k);
        logic [5:0]  msk, aa, ab;
        logic [31:0] oa, ob;
        bit          col;
        msk = 6'((1 << dep_of(k)) - 1);
        if (reset) begin
            m_busy[k] = 1'b1;
            m_rem[k]  = 1 << (dep_of(k) - 1);
            m_col[k]  = 1'b0;
            p1a[k] = '0; p1b[k] = '0; p2a[k] = '0; p2b[k] = '0;
            for (int i = 0; i < 64; i++) mm[k][i] = '0;
        end else begin
            p2a[k] = p1a[k];
            p2b[k] = p1b[k];
            p1a[k] = '0;
            p1b[k] = '0;
            m_col[k] = 1'b0;
            if (!m_busy[k]) begin
                aa  = address_a & msk;
                ab  = address_b & msk;
                oa  = mm[k][aa];
                ob  = mm[k][ab];
                col = wren_a && wren_b && (aa == ab);
                m_col[k] = col;
                p1a[k] = (wren_a && !rdfirst_of(k)) ? merge(oa, data_a, byteena_a) : oa;
                p1b[k] = (wren_b && !col && !rdfirst_of(k)) ? merge(ob, data_b, byteena_b) : ob;
                if (wren_a) mm[k][aa] = merge(oa, data_a, byteena_a);
                if (wren_b && !col) mm[k][ab] = merge(ob, data_b, byteena_b);
            end
            if (m_rem[k] > 0) begin
                m_rem[k]--;
                m_busy[k] = (m_rem[k] > 0);
            end
        end
    endtask

    always @(posedge clock) begin
        if (reset) model_ok = 1'b1;
        for (int k = 0; k < 3; k++) model_step(k);
    end

    always @(negedge clock) begin
        if (model_ok) begin
            for (int k = 0; k < 3; k++) begin
                chk("busy", k, 32'(busy_o[k]), 32'(m_busy[k]));
                chk("collision", k, 32'(coll_o[k]), 32'(m_col[k]));
                chk("q_a", k, qa_o[k], m_busy[k] ? 32'h0 : (oreg_of(k) ? p2a[k] : p1a[k]));
                chk("q_b", k, qb_o[k], m_busy[k] ? 32'h0 : (oreg_of(k) ? p2b[k] : p1b[k]));
            end
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic idle();
        wren_a = 1'b0; wren_b = 1'b0; byteena_a = '0; byteena_b = '0;
    endtask

    task automatic count_busy(input int e0, input int e2, input string nm);
        int c0, c2;
        c0 = 0;
        c2 = 0;
        for (int g = 0; g < 300 && (busy_o != 3'b000); g++) begin
            c0 += int'(busy_o[0]);
            c2 += int'(busy_o[2]);
            tick();
        end
        chk(nm, 0, 32'(c0), 32'(e0));
        chk(nm, 2, 32'(c2), 32'(e2));
    endtask

    initial begin
        reset = 1'b1;
        idle();
        address_a = '0; address_b = '0; data_a = '0; data_b = '0;
        repeat (3) tick();
        reset = 1'b0;
        count_busy(8, 32, "busy_init");

        for (int i = 0; i < 64; i += 2) begin
            wren_a = 1'b1; wren_b = 1'b1; byteena_a = 4'hf; byteena_b = 4'hf;
            address_a = 6'(i); address_b = 6'(i + 1);
            data_a = 32'hDEADBEEF; data_b = 32'hDEADBEEF;
            tick();
        end
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        count_busy(8, 32, "busy_clear");
        for (int i = 0; i < 16; i++) begin
            address_a = 6'(i);
            tick();
            chk("clear_read", 0, qa_o[0], 32'h0);
        end

        wren_a = 1'b1; address_a = 6'd3; data_a = 32'h11223344; byteena_a = 4'b1111;
        tick();
        data_a = 32'hAABBCCDD; byteena_a = 4'b0101;
        tick();
        idle();
        tick();
        chk("byteena_read", 0, qa_o[0], 32'h11BB33DD);

        wren_a = 1'b1; address_a = 6'd7; data_a = 32'h11223344; byteena_a = 4'b1111;
        tick();
        data_a = 32'hAABBCCDD; byteena_a = 4'b0011;
        tick();
        chk("rdw_write_first", 0, qa_o[0], 32'h1122CCDD);
        idle();
        tick();
        chk("rdw_read_first", 1, qa_o[1], 32'h11223344);

        wren_a = 1'b1; wren_b = 1'b1; byteena_a = 4'hf; byteena_b = 4'hf;
        address_a = 6'd5; address_b = 6'd5; data_a = 32'h1; data_b = 32'h2;
        tick();
        chk("collision_pulse", 0, 32'(coll_o[0]), 32'd1);
        chk("collision_qb_old", 0, qb_o[0], 32'h0);
        idle();
        tick();
        chk("collision_end", 0, 32'(coll_o[0]), 32'd0);
        chk("collision_read", 0, qa_o[0], 32'h00000001);

        wren_a = 1'b1; address_a = 6'd9; data_a = 32'hCAFEF00D; byteena_a = 4'hf;
        tick();
        idle();
        address_a = 6'd3;
        tick();
        tick();
        chk("latency_prev", 1, qa_o[1], 32'h11BB33DD);
        address_a = 6'd9;
        tick();
        chk("latency_mid", 1, qa_o[1], 32'h11BB33DD);
        tick();
        chk("latency_data", 1, qa_o[1], 32'hCAFEF00D);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wren_a = 1'b1; address_a = 6'd20; data_a = 32'hFFFFFFFF; byteena_a = 4'hf;
        count_busy(8, 32, "busy_midclear");
        idle();
        tick();
        chk("busy_write_lost", 2, qa_o[2], 32'h0);

        for (int n = 0; n < 3000; n++) begin
            reset     = ($urandom_range(0, 599) == 0);
            wren_a    = 1'($urandom_range(0, 1));
            wren_b    = 1'($urandom_range(0, 1));
            byteena_a = 4'($urandom);
            byteena_b = 4'($urandom);
            address_a = 6'($urandom);
            address_b = ($urandom_range(0, 3) == 0) ? address_a : 6'($urandom);
            data_a    = $urandom;
            data_b    = $urandom;
            tick();
        end
        reset = 1'b0;
        idle();
        repeat (40) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
